// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: FSM states and next-PC select codes.
// Optional cycle counter is controlled by PC_SEQ_CYCLE_COUNT_EN in pc_sequencer.
package pc_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_HOLD = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: picks sequential, branch, jump or current PC by pc_src.
// Purely combinational; the register lives in pc_sequencer.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [1:0]           pc_src,
    input  logic [BUS_WIDTH-1:0] pc_plus4,
    input  logic [BUS_WIDTH-1:0] branch_target,
    input  logic [BUS_WIDTH-1:0] jump_target,
    input  logic [BUS_WIDTH-1:0] pc,
    output logic [BUS_WIDTH-1:0] next_pc
);

    // 4-way select of the next PC value
    always_comb begin
        next_pc = pc;
        case (pc_src)
            PCSRC_SEQ:  next_pc = pc_plus4;
            PCSRC_BR:   next_pc = branch_target;
            PCSRC_JMP:  next_pc = jump_target;
            default:    next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register plus idle/run/step/halt fetch FSM for the IF stage.
// Define PC_SEQ_CYCLE_COUNT_EN to add the cycle_count output.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
    parameter int                PC_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [BUS_WIDTH-1:0] branch_target,
    input  logic                 jump,
    input  logic [BUS_WIDTH-1:0] jump_target,
    input  logic                 halt_detect,
    output logic [BUS_WIDTH-1:0] pc,
    output logic [BUS_WIDTH-1:0] pc_plus4,
    output logic [1:0]           pc_src,
    output logic                 pc_write,
    output logic                 if_flush,
    output logic [1:0]           state,
    output logic                 halted
`ifdef PC_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]          cycle_count
`endif
);

    logic [1:0]           next_state;
    logic [BUS_WIDTH-1:0] next_pc;
    logic                 advancing;

    assign pc_plus4  = pc + BUS_WIDTH'(PC_STEP);
    assign halted    = (state == ST_HALT);
    assign advancing = (state == ST_RUN) || (state == ST_STEP);

    pc_next_sel #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_next_sel (
        .pc_src        (pc_src),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .pc            (pc),
        .next_pc       (next_pc)
    );

    // Mealy advance decision and FSM next-state
    always_comb begin
        pc_src     = PCSRC_HOLD;
        pc_write   = 1'b0;
        if_flush   = 1'b0;
        next_state = state;
        if (advancing) begin
            // Redirects win over stall and over a wrong-path HALT
            if (jump) begin
                pc_src   = PCSRC_JMP;
                pc_write = 1'b1;
                if_flush = 1'b1;
            end else if (branch_taken) begin
                pc_src   = PCSRC_BR;
                pc_write = 1'b1;
                if_flush = 1'b1;
            end else if (stall) begin
                pc_src   = PCSRC_HOLD;
            end else if (halt_detect) begin
                pc_src     = PCSRC_HOLD;
                next_state = ST_HALT;
            end else begin
                pc_src   = PCSRC_SEQ;
                pc_write = 1'b1;
            end
            if (next_state != ST_HALT) begin
                if (state == ST_RUN && step_mode) begin
                    next_state = ST_IDLE;
                end
                if (state == ST_STEP && pc_write) begin
                    next_state = ST_IDLE;
                end
            end
        end else if (state == ST_IDLE) begin
            if (start && !step_mode) begin
                next_state = ST_RUN;
            end else if (step_mode && step_req) begin
                next_state = ST_STEP;
            end
        end
        // No PC update or flush may escape while reset is held
        if (reset) begin
            pc_write = 1'b0;
            if_flush = 1'b0;
        end
    end

    // PC and FSM state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= ST_IDLE;
        end else begin
            state <= next_state;
            if (pc_write) begin
                pc <= next_pc;
            end
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    // Count cycles spent fetching (RUN or STEP)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (advancing) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

    localparam logic [1:0] I = 2'b00, R = 2'b01, S = 2'b10, H = 2'b11;
    localparam logic [1:0] SQ = 2'b00, BR = 2'b01, JM = 2'b10, HD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, step_mode = 1'b0, step_req = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic        halt_detect = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] pc, pc_plus4;
    logic [1:0]  pc_src, state;
    logic        pc_write, if_flush, halted;
`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [1:0]  src;
        logic        wr;
        logic        fl;
        logic        hl;
        logic        rst;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pc_sequencer #(
        .BUS_WIDTH(32),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .step_mode     (step_mode),
        .step_req      (step_req),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_detect   (halt_detect),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .if_flush      (if_flush),
        .state         (state),
        .halted        (halted)
`ifdef PC_SEQ_CYCLE_COUNT_EN
        ,
        .cycle_count   (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, exp);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d",
                         e.name, e.cyc, cyc);
            end else begin
                cmp(e.name, "pc", pc, e.pc);
                cmp(e.name, "pc_plus4", pc_plus4, e.pc + 32'd4);
                cmp(e.name, "state", {30'd0, state}, {30'd0, e.st});
                cmp(e.name, "pc_src", {30'd0, pc_src}, {30'd0, e.src});
                cmp(e.name, "pc_write", {31'd0, pc_write}, {31'd0, e.wr});
                cmp(e.name, "if_flush", {31'd0, if_flush}, {31'd0, e.fl});
                cmp(e.name, "halted", {31'd0, halted}, {31'd0, e.hl});
`ifdef PC_SEQ_CYCLE_COUNT_EN
                if (e.rst) cmp(e.name, "cycle_count", cycle_count, 32'd0);
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] p,
                       input logic [1:0] st, input logic [1:0] src,
                       input logic wr, input logic fl);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.pc   = p;
        e.st   = st;
        e.src  = src;
        e.wr   = wr;
        e.fl   = fl;
        e.hl   = (st == H);
        e.rst  = reset;
        q.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        jump = 0; branch_taken = 0; stall = 0; halt_detect = 0;
        step_req = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("reset", 32'h0, I, HD, 0, 0);
        adv();
        reset = 0;

        start = 1;
        chk("idle_start", 32'h0, I, HD, 0, 0);
        adv();
        for (int i = 0; i < 8; i++) begin
            chk("run_seq", 32'(i * 4), R, SQ, 1, 0);
            adv();
        end

        jump = 1; jump_target = 32'h100;
        branch_taken = 1; branch_target = 32'h80; stall = 1;
        chk("jmp_prio", 32'h20, R, JM, 1, 1);
        adv();
        clr();
        chk("after_jmp", 32'h100, R, SQ, 1, 0);
        adv();

        branch_taken = 1; branch_target = 32'h80; halt_detect = 1;
        chk("br_over_halt", 32'h104, R, BR, 1, 1);
        adv();
        clr();
        stall = 1;
        chk("stall", 32'h80, R, HD, 0, 0);
        adv();
        clr();

        jump = 1; jump_target = 32'hFFFF_FFFC;
        chk("jmp_top", 32'h80, R, JM, 1, 1);
        adv();
        clr();
        chk("top_seq", 32'hFFFF_FFFC, R, SQ, 1, 0);
        adv();
        chk("wrap", 32'h0, R, SQ, 1, 0);
        adv();

        jump = 1; jump_target = 32'h10; step_mode = 1;
        chk("run_to_idle", 32'h4, R, JM, 1, 1);
        adv();
        clr();
        chk("idle_stepmode", 32'h10, I, HD, 0, 0);
        adv();

        step_req = 1;
        chk("step_req", 32'h10, I, HD, 0, 0);
        adv();
        step_req = 0; stall = 1;
        chk("step_stall1", 32'h10, S, HD, 0, 0);
        adv();
        chk("step_stall2", 32'h10, S, HD, 0, 0);
        adv();
        stall = 0;
        chk("step_adv", 32'h10, S, SQ, 1, 0);
        adv();
        chk("step_done", 32'h14, I, HD, 0, 0);
        adv();
        step_req = 1;
        chk("step2_req", 32'h14, I, HD, 0, 0);
        adv();
        step_req = 0;
        chk("step2_adv", 32'h14, S, SQ, 1, 0);
        adv();
        chk("step2_done", 32'h18, I, HD, 0, 0);
        adv();

        step_mode = 0;
        chk("restart", 32'h18, I, HD, 0, 0);
        adv();
        jump = 1; jump_target = 32'h40;
        chk("jmp_40", 32'h18, R, JM, 1, 1);
        adv();
        clr();
        halt_detect = 1;
        chk("halt_det", 32'h40, R, HD, 0, 0);
        adv();
        clr();
        for (int i = 0; i < 10; i++) begin
            step_req = i[0];
            step_mode = i[1];
            jump = i[2]; jump_target = 32'h300;
            chk("halted", 32'h40, H, HD, 0, 0);
            adv();
        end
        clr();
        step_mode = 0;
        reset = 1;
        chk("halt_reset", 32'h0, I, HD, 0, 0);
        adv();
        reset = 0;

        chk("rs_idle", 32'h0, I, HD, 0, 0);
        adv();
        jump = 1; jump_target = 32'h200; step_mode = 1; start = 0;
        chk("rs_jmp", 32'h0, R, JM, 1, 1);
        adv();
        clr();
        step_req = 1;
        chk("rs_req", 32'h200, I, HD, 0, 0);
        adv();
        step_req = 0; stall = 1;
        chk("rs_stall", 32'h200, S, HD, 0, 0);
        adv();
        reset = 1;
        chk("mid_step_reset", 32'h0, I, HD, 0, 0);
        adv();
        reset = 0; stall = 0;
        chk("step_dropped", 32'h0, I, HD, 0, 0);
        adv();

        adv();
        adv();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
